// File: rtl/vga_sync_gen.sv
// VGA pixel timing: clock divider, h/v counters, sync decode and source-aligned output stage.
// Optional VGA_SYNC_FRAME_LATCH_EN: mode selects only reload on frame_start.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SRC_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  sw_size,
  input  logic [2:0]  sw_rgb,
  input  logic [11:0] rgb_in,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [1:0]  size,
  output logic [2:0]  rgb,
  output logic        pix_tick,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [11:0] rgb_out
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT     = 11'(H_DISPLAY);
  localparam logic [10:0] V_ACT     = 11'(V_DISPLAY);
  localparam logic [10:0] H_SYNC_LO = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] H_SYNC_HI = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SYNC_LO = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] V_SYNC_HI = 11'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [10:0]      x_q, x_d;
  logic [10:0]      y_q, y_d;
  logic [1:0]       size_q, size_d;
  logic [2:0]       rgb_q, rgb_d;
  logic             tick;
  logic             frame_wrap;

  logic             hs_raw, vs_raw, von_raw;
  logic [SRC_DELAY-1:0] hs_dly_q, hs_dly_d;
  logic [SRC_DELAY-1:0] vs_dly_q, vs_dly_d;
  logic [SRC_DELAY-1:0] von_dly_q, von_dly_d;

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic [11:0]      rgb_out_q, rgb_out_d;

  always_comb begin
    div_cnt_d  = div_cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    tick       = (div_cnt_q == DIV_LAST);
    frame_wrap = tick && (x_q == H_LAST) && (y_q == V_LAST);

    if (tick) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    // The line wrap and the frame wrap land on the same tick.
    if (tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? 11'd0 : (y_q + 11'd1);
      end else begin
        x_d = x_q + 11'd1;
      end
    end
  end

  always_comb begin
    hs_raw  = !((x_q >= H_SYNC_LO) && (x_q < H_SYNC_HI));
    vs_raw  = !((y_q >= V_SYNC_LO) && (y_q < V_SYNC_HI));
    von_raw = (x_q < H_ACT) && (y_q < V_ACT);
  end

  // Delay lines advance every clock so alignment is independent of the tick rate.
  always_comb begin
    hs_dly_d     = hs_dly_q;
    vs_dly_d     = vs_dly_q;
    von_dly_d    = von_dly_q;
    hs_dly_d[0]  = hs_raw;
    vs_dly_d[0]  = vs_raw;
    von_dly_d[0] = von_raw;
    for (int i = 1; i < SRC_DELAY; i++) begin
      hs_dly_d[i]  = hs_dly_q[i-1];
      vs_dly_d[i]  = vs_dly_q[i-1];
      von_dly_d[i] = von_dly_q[i-1];
    end
  end

  always_comb begin
    hsync_d    = hs_dly_q[SRC_DELAY-1];
    vsync_d    = vs_dly_q[SRC_DELAY-1];
    video_on_d = von_dly_q[SRC_DELAY-1];
    rgb_out_d  = von_dly_q[SRC_DELAY-1] ? rgb_in : 12'h000;
  end

  always_comb begin
    size_d = size_q;
    rgb_d  = rgb_q;
`ifdef VGA_SYNC_FRAME_LATCH_EN
    if (frame_wrap) begin
      size_d = sw_size;
      rgb_d  = sw_rgb;
    end
`else
    size_d = sw_size;
    rgb_d  = sw_rgb;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      x_q        <= '0;
      y_q        <= '0;
      size_q     <= '0;
      rgb_q      <= '0;
      hs_dly_q   <= '1;
      vs_dly_q   <= '1;
      von_dly_q  <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
      rgb_out_q  <= 12'h000;
    end else begin
      div_cnt_q  <= div_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      size_q     <= size_d;
      rgb_q      <= rgb_d;
      hs_dly_q   <= hs_dly_d;
      vs_dly_q   <= vs_dly_d;
      von_dly_q  <= von_dly_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
      rgb_out_q  <= rgb_out_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign size        = size_q;
  assign rgb         = rgb_q;
  assign pix_tick    = tick;
  assign frame_start = frame_wrap;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign rgb_out     = rgb_out_q;

endmodule
